// File: rtl/sprites.sv
// -----------------------------------------------------------------------------
// sprites -- VGA sprite demo for the Go board.
//
// Generates 640x480@60 raster timing from a 25 MHz pixel clock, draws a
// 256x256 tiled playfield of 2-bit pixels (window at column 16, row 0), overlays
// one 16x16 switch-driven sprite, maps pixels through a fixed 4-entry palette to
// 3-bit RGB and shows the sprite X position in hex on the two 7-seg digits.
//
// Ports
//   i_Clk, i_Reset              25 MHz pixel clock, synchronous active-high reset
//   i_Switch_1..4               up / down / left / right requests (asynchronous)
//   o_VGA_HSync, o_VGA_VSync    active-low syncs (registered)
//   o_VGA_{Red,Grn,Blu}_0..2    3-bit colour channels, _2 = MSB (registered)
//   o_Segment1_A..G             active-low digit showing sprite X[7:4]
//   o_Segment2_A..G             active-low digit showing sprite X[3:0]
//   o_LED_1..4                  synchronized switch levels
//   tb_row, tb_column           live raster counters
//   tb_pixel                    2-bit pixel at (tb_row, tb_column), combinational
// -----------------------------------------------------------------------------
module sprites (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Switch_1,
  input  logic       i_Switch_2,
  input  logic       i_Switch_3,
  input  logic       i_Switch_4,
  output logic       o_VGA_HSync,
  output logic       o_VGA_VSync,
  output logic       o_VGA_Red_0,
  output logic       o_VGA_Red_1,
  output logic       o_VGA_Red_2,
  output logic       o_VGA_Grn_0,
  output logic       o_VGA_Grn_1,
  output logic       o_VGA_Grn_2,
  output logic       o_VGA_Blu_0,
  output logic       o_VGA_Blu_1,
  output logic       o_VGA_Blu_2,
  output logic       o_Segment1_A,
  output logic       o_Segment1_B,
  output logic       o_Segment1_C,
  output logic       o_Segment1_D,
  output logic       o_Segment1_E,
  output logic       o_Segment1_F,
  output logic       o_Segment1_G,
  output logic       o_Segment2_A,
  output logic       o_Segment2_B,
  output logic       o_Segment2_C,
  output logic       o_Segment2_D,
  output logic       o_Segment2_E,
  output logic       o_Segment2_F,
  output logic       o_Segment2_G,
  output logic       o_LED_1,
  output logic       o_LED_2,
  output logic       o_LED_3,
  output logic       o_LED_4,
  output logic [9:0] tb_row,
  output logic [9:0] tb_column,
  output logic [1:0] tb_pixel
);

  localparam logic [9:0] H_LAST   = 10'd799;
  localparam logic [9:0] V_LAST   = 10'd524;
  localparam logic [9:0] H_VIS    = 10'd640;
  localparam logic [9:0] V_VIS    = 10'd480;
  localparam logic [9:0] HS_START = 10'd656;
  localparam logic [9:0] HS_END   = 10'd751;
  localparam logic [9:0] VS_START = 10'd490;
  localparam logic [9:0] VS_END   = 10'd491;
  localparam logic [9:0] WIN_X0   = 10'd16;
  localparam logic [9:0] WIN_X1   = 10'd272;
  localparam logic [9:0] WIN_Y1   = 10'd256;
  localparam logic [7:0] POS_INIT = 8'd120;
  localparam logic [7:0] POS_MAX  = 8'd240;
  localparam logic [7:0] SPR_SIZE = 8'd16;

  // One 16x16 tile of pattern k at local (x, y).
  function automatic logic [1:0] tile_pixel(input logic [1:0] k,
                                            input logic [3:0] x,
                                            input logic [3:0] y);
    logic [1:0] p;
    p = 2'd0;
    case (k)
      2'd0: p = 2'd0;
      2'd1: if (x == 4'd0 || x == 4'd15 || y == 4'd0 || y == 4'd15) p = 2'd1;
      2'd2: if (x[2] ^ y[2]) p = 2'd2;
      default: if (x == y || x == (4'd15 - y)) p = 2'd3;
    endcase
    return p;
  endfunction

  // Palette, packed {R[2:0], G[2:0], B[2:0]}.
  function automatic logic [8:0] palette(input logic [1:0] p);
    logic [8:0] c;
    case (p)
      2'd0:    c = 9'b000_000_000;
      2'd1:    c = 9'b111_111_111;
      2'd2:    c = 9'b000_000_111;
      default: c = 9'b111_111_000;
    endcase
    return c;
  endfunction

  // Hex glyph, active-low, packed {A,B,C,D,E,F,G}.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  logic [9:0] col_q, col_d;
  logic [9:0] row_q, row_d;
  logic [7:0] sx_q, sx_d;
  logic [7:0] sy_q, sy_d;
  logic [3:0] sw_meta_q, sw_meta_d;
  logic [3:0] sw_sync_q, sw_sync_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic [8:0] rgb_q, rgb_d;

  logic       frame_end;
  logic       in_win;
  logic       in_spr;
  logic       visible;
  logic [7:0] wx, wy;
  logic [7:0] spr_dx, spr_dy;
  logic [1:0] tile_k;
  logic [1:0] bg_px, spr_px, pixel;
  logic       mv_up, mv_dn, mv_lt, mv_rt;
  logic [6:0] seg1, seg2;

  always_comb begin
    // Raster counters
    col_d = col_q + 10'd1;
    row_d = row_q;
    if (col_q == H_LAST) begin
      col_d = 10'd0;
      row_d = (row_q == V_LAST) ? 10'd0 : row_q + 10'd1;
    end
    frame_end = (row_q == V_LAST) && (col_q == H_LAST);

    // Switch synchronizer: bit 0 = up, 1 = down, 2 = left, 3 = right
    sw_meta_d = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};
    sw_sync_d = sw_meta_q;
    mv_up = sw_sync_q[0];
    mv_dn = sw_sync_q[1];
    mv_lt = sw_sync_q[2];
    mv_rt = sw_sync_q[3];

    // Sprite moves only at the very last pixel of a frame, so the whole next
    // frame is drawn at one consistent position. Opposing requests cancel.
    sx_d = sx_q;
    sy_d = sy_q;
    if (frame_end) begin
      if (mv_lt && !mv_rt && sx_q != 8'd0)         sx_d = sx_q - 8'd1;
      else if (mv_rt && !mv_lt && sx_q < POS_MAX)  sx_d = sx_q + 8'd1;
      if (mv_up && !mv_dn && sy_q != 8'd0)         sy_d = sy_q - 8'd1;
      else if (mv_dn && !mv_up && sy_q < POS_MAX)  sy_d = sy_q + 8'd1;
    end

    // Window coordinates; the low 8 bits of (col - 16) are exact inside the window
    in_win = (row_q < WIN_Y1) && (col_q >= WIN_X0) && (col_q < WIN_X1);
    wx     = col_q[7:0] - 8'd16;
    wy     = row_q[7:0];

    // Playfield: pattern index is (ty + tx) mod 4, i.e. only bits [5:4] matter
    tile_k = wy[5:4] + wx[5:4];
    bg_px  = tile_pixel(tile_k, wx[3:0], wy[3:0]);

    // Sprite box test; the subtraction is only meaningful when wx >= sx
    spr_dx = wx - sx_q;
    spr_dy = wy - sy_q;
    in_spr = (wx >= sx_q) && (spr_dx < SPR_SIZE) &&
             (wy >= sy_q) && (spr_dy < SPR_SIZE);
    spr_px = tile_pixel(2'd3, spr_dx[3:0], spr_dy[3:0]);

    pixel = 2'd0;
    if (in_win) pixel = (in_spr && spr_px != 2'd0) ? spr_px : bg_px;

    // Output stage inputs, registered below to line up syncs with colour
    visible = (col_q < H_VIS) && (row_q < V_VIS);
    rgb_d   = visible ? palette(pixel) : 9'd0;
    hsync_d = !((col_q >= HS_START) && (col_q <= HS_END));
    vsync_d = !((row_q >= VS_START) && (row_q <= VS_END));

    seg1 = hex7(sx_q[7:4]);
    seg2 = hex7(sx_q[3:0]);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      col_q     <= 10'd0;
      row_q     <= 10'd0;
      sx_q      <= POS_INIT;
      sy_q      <= POS_INIT;
      sw_meta_q <= 4'd0;
      sw_sync_q <= 4'd0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      rgb_q     <= 9'd0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      sx_q      <= sx_d;
      sy_q      <= sy_d;
      sw_meta_q <= sw_meta_d;
      sw_sync_q <= sw_sync_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      rgb_q     <= rgb_d;
    end
  end

  assign tb_row    = row_q;
  assign tb_column = col_q;
  assign tb_pixel  = pixel;

  assign o_VGA_HSync = hsync_q;
  assign o_VGA_VSync = vsync_q;
  assign {o_VGA_Red_2, o_VGA_Red_1, o_VGA_Red_0,
          o_VGA_Grn_2, o_VGA_Grn_1, o_VGA_Grn_0,
          o_VGA_Blu_2, o_VGA_Blu_1, o_VGA_Blu_0} = rgb_q;

  assign {o_Segment1_A, o_Segment1_B, o_Segment1_C, o_Segment1_D,
          o_Segment1_E, o_Segment1_F, o_Segment1_G} = seg1;
  assign {o_Segment2_A, o_Segment2_B, o_Segment2_C, o_Segment2_D,
          o_Segment2_E, o_Segment2_F, o_Segment2_G} = seg2;

  assign {o_LED_4, o_LED_3, o_LED_2, o_LED_1} = sw_sync_q;

endmodule

// File: tb/tb_sprites.sv
// -----------------------------------------------------------------------------
// tb_sprites -- directed bench for the sprites VGA demo.
// Pixel/colour probes come from a vector table; raster position is preset with
// force/release on the counters so that distant rows and frame ends are reached
// in a handful of cycles.
// -----------------------------------------------------------------------------
module tb_sprites;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sw1 = 1'b0, sw2 = 1'b0, sw3 = 1'b0, sw4 = 1'b0;

  logic hs, vs;
  logic r0, r1, r2, g0, g1, g2, b0, b1, b2;
  logic s1a, s1b, s1c, s1d, s1e, s1f, s1g;
  logic s2a, s2b, s2c, s2d, s2e, s2f, s2g;
  logic led1, led2, led3, led4;
  logic [9:0] row, col;
  logic [1:0] pix;

  logic [8:0] rgb;
  logic [6:0] seg1, seg2;
  assign rgb  = {r2, r1, r0, g2, g1, g0, b2, b1, b0};
  assign seg1 = {s1a, s1b, s1c, s1d, s1e, s1f, s1g};
  assign seg2 = {s2a, s2b, s2c, s2d, s2e, s2f, s2g};

  sprites dut (
    .i_Clk(clk), .i_Reset(rst),
    .i_Switch_1(sw1), .i_Switch_2(sw2), .i_Switch_3(sw3), .i_Switch_4(sw4),
    .o_VGA_HSync(hs), .o_VGA_VSync(vs),
    .o_VGA_Red_0(r0), .o_VGA_Red_1(r1), .o_VGA_Red_2(r2),
    .o_VGA_Grn_0(g0), .o_VGA_Grn_1(g1), .o_VGA_Grn_2(g2),
    .o_VGA_Blu_0(b0), .o_VGA_Blu_1(b1), .o_VGA_Blu_2(b2),
    .o_Segment1_A(s1a), .o_Segment1_B(s1b), .o_Segment1_C(s1c), .o_Segment1_D(s1d),
    .o_Segment1_E(s1e), .o_Segment1_F(s1f), .o_Segment1_G(s1g),
    .o_Segment2_A(s2a), .o_Segment2_B(s2b), .o_Segment2_C(s2c), .o_Segment2_D(s2d),
    .o_Segment2_E(s2e), .o_Segment2_F(s2f), .o_Segment2_G(s2g),
    .o_LED_1(led1), .o_LED_2(led2), .o_LED_3(led3), .o_LED_4(led4),
    .tb_row(row), .tb_column(col), .tb_pixel(pix)
  );

  always #20 clk = ~clk;

  localparam logic [6:0] GLYPH_7 = 7'b0001111;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_B = 7'b1100000;
  localparam logic [8:0] BLACK   = 9'h000;
  localparam logic [8:0] WHITE   = 9'h1FF;
  localparam logic [8:0] BLUE    = 9'h007;
  localparam logic [8:0] YELLOW  = 9'h1F8;

  typedef struct {
    logic [9:0] r;
    logic [9:0] c;
    logic [1:0] px;
    logic [8:0] col_rgb;
  } vec_t;

  vec_t vecs [13];

  int n_total = 0;
  int n_bad   = 0;
  logic [9:0]  dep_r, dep_c;
  logic [31:0] cap0, cap1, cap2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_total++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, want);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Preset the raster counters; called in the low phase of the clock.
  task automatic deposit(input logic [9:0] r, input logic [9:0] c);
    dep_r = r;
    dep_c = c;
    force dut.row_q = dep_r;
    force dut.col_q = dep_c;
    #1;
    release dut.row_q;
    release dut.col_q;
    #1;
  endtask

  // Jump to just before the frame end and clock through the move cycle.
  task automatic skip_frame();
    deposit(10'd524, 10'd798);
    tick();
    tick();
  endtask

  task automatic probe(input string name, input logic [9:0] r, input logic [9:0] c,
                       input logic [1:0] want);
    deposit(r, c);
    check(name, {30'd0, pix}, {30'd0, want});
  endtask

  initial begin
    vecs[0]  = '{10'd120, 10'd136, 2'd3, YELLOW};  // sprite top-left
    vecs[1]  = '{10'd120, 10'd137, 2'd0, BLACK};   // transparent sprite over k=2 zero
    vecs[2]  = '{10'd120, 10'd141, 2'd2, BLUE};    // transparent sprite over k=2 two
    vecs[3]  = '{10'd0,   10'd32,  2'd1, WHITE};   // k=1 border
    vecs[4]  = '{10'd5,   10'd69,  2'd3, YELLOW};  // k=3 diagonal
    vecs[5]  = '{10'd5,   10'd74,  2'd3, YELLOW};  // k=3 anti-diagonal
    vecs[6]  = '{10'd5,   10'd70,  2'd0, BLACK};   // k=3 off diagonal
    vecs[7]  = '{10'd300, 10'd100, 2'd0, BLACK};   // below window
    vecs[8]  = '{10'd10,  10'd5,   2'd0, BLACK};   // left of window
    vecs[9]  = '{10'd15,  10'd271, 2'd3, YELLOW};  // last window column
    vecs[10] = '{10'd15,  10'd272, 2'd0, BLACK};   // first column past window
    vecs[11] = '{10'd135, 10'd151, 2'd3, YELLOW};  // sprite bottom-right
    vecs[12] = '{10'd136, 10'd152, 2'd0, BLACK};   // just past sprite, k=0

    // Reset state
    repeat (3) tick();
    check("rst_row", {22'd0, row}, 32'd0);
    check("rst_col", {22'd0, col}, 32'd0);
    check("rst_hs", {31'd0, hs}, 32'd1);
    check("rst_vs", {31'd0, vs}, 32'd1);
    check("rst_rgb", {23'd0, rgb}, 32'd0);
    check("rst_led", {28'd0, led4, led3, led2, led1}, 32'd0);
    check("rst_seg1", {25'd0, seg1}, {25'd0, GLYPH_7});
    check("rst_seg2", {25'd0, seg2}, {25'd0, GLYPH_8});

    // First line: counter, pixel capture and horizontal sync
    rst = 1'b0;
    cap0 = '0; cap1 = '0; cap2 = '0;
    for (int c = 0; c < 800; c++) begin
      if (c == 0 || c == 400 || c == 799) check("col_count", {22'd0, col}, c);
      if (c >= 16 && c < 32) cap0 = {cap0[29:0], pix};
      if (c >= 32 && c < 48) cap1 = {cap1[29:0], pix};
      if (c >= 48 && c < 64) cap2 = {cap2[29:0], pix};
      if (c == 400) check("vs_row0", {31'd0, vs}, 32'd1);
      if (c == 656) check("hs_655", {31'd0, hs}, 32'd1);
      if (c == 657) check("hs_656", {31'd0, hs}, 32'd0);
      if (c == 752) check("hs_751", {31'd0, hs}, 32'd0);
      if (c == 753) check("hs_752", {31'd0, hs}, 32'd1);
      tick();
    end
    check("wrap_row", {22'd0, row}, 32'd1);
    check("wrap_col", {22'd0, col}, 32'd0);
    check("cap_16_31", cap0, 32'h00000000);
    check("cap_32_47", cap1, 32'h55555555);
    check("cap_48_63", cap2, 32'h00AA00AA);

    // Vertical sync edges
    deposit(10'd489, 10'd798);
    tick(); check("vs_489", {31'd0, vs}, 32'd1);
    tick(); check("vs_489e", {31'd0, vs}, 32'd1);
    tick(); check("vs_490", {31'd0, vs}, 32'd0);
    deposit(10'd491, 10'd799);
    tick(); check("vs_491e", {31'd0, vs}, 32'd0);
    tick(); check("vs_492", {31'd0, vs}, 32'd1);

    // Pixel and colour vectors; colour appears one cycle after the pixel
    for (int i = 0; i < 13; i++) begin
      deposit(vecs[i].r, vecs[i].c);
      check($sformatf("pix_%0d", i), {30'd0, pix}, {30'd0, vecs[i].px});
      tick();
      check($sformatf("rgb_%0d", i), {23'd0, rgb}, {23'd0, vecs[i].col_rgb});
    end

    // Switch synchronizer latency and move right
    sw4 = 1'b1;
    tick(); check("led4_1cyc", {31'd0, led4}, 32'd0);
    tick(); check("led4_2cyc", {31'd0, led4}, 32'd1);
    check("seg2_premove", {25'd0, seg2}, {25'd0, GLYPH_8});
    repeat (3) skip_frame();
    check("right_seg1", {25'd0, seg1}, {25'd0, GLYPH_7});
    check("right_seg2", {25'd0, seg2}, {25'd0, GLYPH_B});
    probe("right_pix", 10'd120, 10'd139, 2'd3);

    // Opposing left+right cancel
    sw3 = 1'b1;
    repeat (3) tick();
    check("led3", {31'd0, led3}, 32'd1);
    repeat (2) skip_frame();
    check("cancel_seg1", {25'd0, seg1}, {25'd0, GLYPH_7});
    check("cancel_seg2", {25'd0, seg2}, {25'd0, GLYPH_B});

    // Mid-frame reset
    sw3 = 1'b0; sw4 = 1'b0;
    deposit(10'd200, 10'd300);
    tick();
    rst = 1'b1;
    tick();
    check("midrst_row", {22'd0, row}, 32'd0);
    check("midrst_col", {22'd0, col}, 32'd0);
    check("midrst_seg2", {25'd0, seg2}, {25'd0, GLYPH_8});
    rst = 1'b0;

    // Up clamps at 0
    sw1 = 1'b1;
    repeat (3) tick();
    repeat (130) skip_frame();
    check("up_seg1", {25'd0, seg1}, {25'd0, GLYPH_7});
    check("up_seg2", {25'd0, seg2}, {25'd0, GLYPH_8});
    probe("up_top", 10'd0, 10'd136, 2'd3);
    probe("up_bot", 10'd15, 10'd151, 2'd3);

    // Down clamps at 240
    sw1 = 1'b0; sw2 = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    repeat (130) skip_frame();
    probe("dn_top", 10'd240, 10'd136, 2'd3);
    probe("dn_bot", 10'd255, 10'd151, 2'd3);
    probe("dn_above", 10'd239, 10'd136, 2'd1);
    sw2 = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
